zxw_sw_conditioner: RTL and testbench

Switch-input conditioner sitting directly upstream of `zxw_lab2`. It synchronises the five raw board switches to `Clock`, debounces each bit independently, and drives the clean `SW_in` bus of the lab2 datapath. It can optionally also provide one-cycle rise and fall strobes per bit for edge-triggered control.

---
 rtl/zxw_pkg.sv | 12 +
 rtl/zxw_bit_debounce.sv | 67 ++++++
 rtl/zxw_sw_conditioner.sv | 41 ++++
 tb/tb_zxw_sw_conditioner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/zxw_pkg.sv
// Shared constants and helpers for the zxw switch conditioner.
package zxw_pkg;

  localparam int ZXW_SW_WIDTH         = 5;
  localparam int ZXW_DEBOUNCE_DEFAULT = 4;

  // Counter width for a debounce length of n, never narrower than one bit.
  function automatic int zxw_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zxw_bit_debounce.sv
// One switch bit: 2-flop synchroniser, disagreement counter and held value.
// Rise/fall strobe registers exist only when ZXW_SW_EDGE_EN is defined.
import zxw_pkg::*;

module zxw_bit_debounce #(
  parameter int DEBOUNCE_CYCLES = ZXW_DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_out
`ifdef ZXW_SW_EDGE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);

  localparam int CW = zxw_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_hold;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_commit;

  assign w_diff   = r_s2 ^ r_hold;
  assign w_commit = w_diff && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_hold <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any agreeing sample discards a partial run, so short glitches never commit.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_hold <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out = r_hold;

`ifdef ZXW_SW_EDGE_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= w_commit &  r_s2;
      o_fall <= w_commit & ~r_s2;
    end
  end
`endif

endmodule

// File: rtl/zxw_sw_conditioner.sv
// Synchronises and debounces the board switches feeding zxw_lab2 SW_in.
// Define ZXW_SW_EDGE_EN to add per-bit rise/fall strobes and SW_change.
import zxw_pkg::*;

module zxw_sw_conditioner #(
  parameter int WIDTH           = ZXW_SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = ZXW_DEBOUNCE_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW_out
`ifdef ZXW_SW_EDGE_EN
  ,
  output logic [WIDTH-1:0] SW_rise,
  output logic [WIDTH-1:0] SW_fall,
  output logic             SW_change
`endif
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    zxw_bit_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk (Clock),
      .i_rst (Reset),
      .i_raw (SW_raw[g]),
      .o_out (SW_out[g])
`ifdef ZXW_SW_EDGE_EN
      ,
      .o_rise(SW_rise[g]),
      .o_fall(SW_fall[g])
`endif
    );
  end

`ifdef ZXW_SW_EDGE_EN
  assign SW_change = |(SW_rise | SW_fall);
`endif

endmodule

// File: tb/tb_zxw_sw_conditioner.sv
// Scoreboard bench for zxw_sw_conditioner: directed scenarios then random switch activity.
module tb_zxw_sw_conditioner;

  localparam int W  = 5;
  localparam int DC = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] SW_raw;
  logic [W-1:0] SW_out;
`ifdef ZXW_SW_EDGE_EN
  logic [W-1:0] SW_rise;
  logic [W-1:0] SW_fall;
  logic         SW_change;
`endif

  zxw_sw_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .SW_raw   (SW_raw),
    .SW_out   (SW_out)
`ifdef ZXW_SW_EDGE_EN
    ,
    .SW_rise  (SW_rise),
    .SW_fall  (SW_fall),
    .SW_change(SW_change)
`endif
  );

  always #5 Clock = ~Clock;

  exp_t         sb[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_hold;
  bit           run = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  // Reference: a bit flips when the DC most recent synchronised samples
  // (raw values seen two edges earlier and before) all oppose the held value.
  function automatic exp_t model_edge(input logic [W-1:0] raw, input logic rst);
    exp_t e;
    e = '0;
    if (rst) begin
      hist.delete();
      m_hold = '0;
    end else begin
      hist.push_back(raw);
      for (int b = 0; b < W; b++) begin
        bit all_opp;
        all_opp = 1'b1;
        for (int k = 0; k < DC; k++) begin
          int idx;
          logic v;
          idx = hist.size() - 3 - k;
          v = (idx >= 0) ? hist[idx][b] : 1'b0;
          if (v == m_hold[b]) all_opp = 1'b0;
        end
        if (all_opp) begin
          m_hold[b] = ~m_hold[b];
          if (m_hold[b]) e.rise[b] = 1'b1;
          else           e.fall[b] = 1'b1;
        end
      end
      e.out = m_hold;
    end
    return e;
  endfunction

  task automatic step(input logic [W-1:0] raw, input logic rst);
    logic was_rst;
    @(negedge Clock);
    was_rst = Reset;
    Reset   = rst;
    SW_raw  = raw;
    sb.push_back(model_edge(raw, rst));
    run = 1'b1;
    if (rst && !was_rst) begin
      #1;
      check("async_reset_out", SW_out, '0);
`ifdef ZXW_SW_EDGE_EN
      check("async_reset_rise", SW_rise, '0);
      check("async_reset_fall", SW_fall, '0);
`endif
    end
  endtask

  task automatic hold_for(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (run) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
      end else begin
        e = sb.pop_front();
        check("SW_out", SW_out, e.out);
`ifdef ZXW_SW_EDGE_EN
        check("SW_rise", SW_rise, e.rise);
        check("SW_fall", SW_fall, e.fall);
        check("SW_change", {{(W-1){1'b0}}, SW_change}, {{(W-1){1'b0}}, |(e.rise | e.fall)});
`endif
      end
    end
  end

  initial begin
    Reset  = 1'b1;
    SW_raw = 5'b11111;
    m_hold = '0;
    #1;
    check("reset_out_t0", SW_out, '0);
`ifdef ZXW_SW_EDGE_EN
    check("reset_change_t0", {{(W-1){1'b0}}, SW_change}, '0);
`endif
    for (int i = 0; i < 3; i++) step(5'b11111, 1'b1);
    hold_for(5'b11111, 9);
    hold_for(5'b00000, 9);
    hold_for(5'b00101, 9);
    hold_for(5'b00000, 9);
    // Glitches on bit 2: 3 cycles (rejected), then 4 cycles (accepted).
    hold_for(5'b00100, 3);
    hold_for(5'b00000, 9);
    hold_for(5'b00100, 4);
    hold_for(5'b00000, 12);
    hold_for(5'b00011, 9);
    hold_for(5'b11100, 9);
    hold_for(5'b00000, 9);
    // Reset three edges into a pending change, then full latency again.
    hold_for(5'b10000, 3);
    step(5'b10000, 1'b1);
    step(5'b10000, 1'b1);
    hold_for(5'b10000, 9);
    for (int s = 0; s < 120; s++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      hold_for(v, $urandom_range(1, 7));
    end
    hold_for(5'b01010, 10);
    @(posedge Clock);
    #2;
    run = 1'b0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
